rx_frame_sched: RTL and testbench
=================================

// Module: rx_frame_sched
// PURPOSE
//  Schedules RX-RAM decode frames for the V (6-bit symbol) and N (4-bit symbol) decoders.
//  Arbitrates two frame requesters round-robin, latches the winner's frame length and drives
//  the decoder control set (data_std, cod_ce_v/cod_ce_n, weight_pack).
//  Closes each frame on the decoder's flag_down_last_data and enforces an idle gap between frames.
//  Sits between the frame requesters and the RX symbol decoder, on the decoder clock.
// PARAMETERS
//  LEN_W        10    width of frame length / weight_pack (last RAM word index)
//  GAP_CYC      4     idle cycles between data_std fall and next possible grant (>=1)
//  TIMEOUT_CYC  4096  RUN-state watchdog limit in clk_15_o cycles (used only with RX_SCHED_TIMEOUT_EN)
// PORTS
//  clk_15_o             in   1      decoder clock; single clock domain
//  nrst                 in   1      asynchronous, active-low reset
//  req_v                in   1      V-frame request, level; held until gnt_v
//  len_v                in   LEN_W  V-frame last word index; valid while req_v=1
//  req_n                in   1      N-frame request, level; held until gnt_n
//  len_n                in   LEN_W  N-frame last word index; valid while req_n=1
//  flag_down_last_data  in   1      decoder end-of-frame indication
//  gnt_v / gnt_n        out  1      one-cycle grant pulse
//  done_v / done_n      out  1      one-cycle frame-complete pulse
//  data_std             out  1      frame window to decoder
//  cod_ce_v / cod_ce_n  out  1      decoder mode select; one-hot or both 0
//  weight_pack          out  LEN_W  latched length of the active frame
//  busy                 out  1      1 in every state except IDLE
//  timeout_err          out  1      sticky watchdog flag; tied 0 when the macro is absent
// BEHAVIOUR
//  - Reset (async, nrst=0): all outputs 0, state IDLE, gap counter 0, last_grant=N so V wins first.
//  - All outputs are registered.
//  - State IDLE: sample req_v/req_n.
//      One request: grant it.
//      Both: grant the side opposite last_grant.
//      On grant: latch len and mode, pulse gnt_x, -> LOAD.
//      gnt_x is high in the cycle after req was seen, so a requester sampling gnt sees it at t+1.
//  - State LOAD (1 cycle): weight_pack=len, cod_ce_x=1, data_std=0, so weight and mode are stable
//    before the window opens. -> RUN.
//  - State RUN: data_std=1, cod_ce_x=1. flag_down_last_data=1 -> DRAIN.
//    The flag is ignored in all other states.
//  - State DRAIN (1 cycle): data_std=0, cod_ce_x held for the decoder's falling-edge clear,
//    done_x=1. -> GAP.
//  - State GAP: cod_ce_v=cod_ce_n=0, weight_pack holds. Count GAP_CYC cycles -> IDLE.
//    Requests arriving in GAP wait in place; none are lost.
//  - Latency: req at cycle t -> gnt t+1 -> data_std rises t+2.
//    flag at cycle f -> data_std=0 and done at f+1.
//  - len=0 is legal (single RAM word frame); no special casing.
//  - A req that stays high past done is treated as a new frame request.
//  - A requester dropping req before its grant loses the request silently.
//  - Reset mid-frame: immediate return to IDLE, all outputs 0, no done pulse.
// CONFIGURATION
//  RX_SCHED_TIMEOUT_EN defined:
//    - A RUN cycle counter counts up from 0 on entry to RUN.
//    - Reaching TIMEOUT_CYC-1 without the flag forces DRAIN, pulses done_x and sets timeout_err.
//    - timeout_err stays set until the next grant.
//  RX_SCHED_TIMEOUT_EN undefined: RUN waits indefinitely, no counter, timeout_err tied 0.
// STRUCTURE
//  - Package rx_sched_pkg:
//      sched_state_t enum {IDLE, LOAD, RUN, DRAIN, GAP}
//      sched_mode_t  enum {MODE_V, MODE_N}
//      default GAP_CYC and TIMEOUT_CYC constants
//  - Sub-module rr_arb2: 2-way round-robin arbiter.
//      Inputs: req[1:0], last_grant, en.
//      Outputs: one-hot grant.
//      Purely combinational; the last_grant register stays in rx_frame_sched.
// TESTING
//  1. Single V: req_v=1, len_v=3 -> gnt_v at t+1; weight_pack=3, cod_ce_v=1 at t+1;
//     data_std=1 at t+2; flag -> data_std=0, done_v next cycle; busy=0 after 4 gap cycles.
//  2. Simultaneous req_v/req_n after reset -> V granted first, N granted after V's GAP;
//     cod_ce_n=1 only in N frame.
//  3. Back-to-back: req_n held high across 3 frames with req_v idle -> 3 N frames,
//     each separated by exactly GAP_CYC idle cycles.
//  4. len=0 frame plus flag in the first RUN cycle -> DRAIN next cycle, correct done pulse,
//     no stuck state.
//  5. nrst low for 1 cycle during RUN -> all outputs 0 immediately, no done;
//     a pending req is granted normally after reset release.
//  6. With RX_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, flag never asserted ->
//     DRAIN after 16 RUN cycles, done_v pulse, timeout_err=1 until next gnt.

Source files
------------

// File: rtl/rx_sched_pkg.sv
// Shared types and default constants for the RX frame scheduler.
package rx_sched_pkg;

  // Scheduler FSM states, in frame order
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    GAP
  } sched_state_t;

  // Which decoder the active (or most recent) frame belongs to
  typedef enum logic {
    MODE_V,
    MODE_N
  } sched_mode_t;

  // Default frame-length width, inter-frame gap and RUN watchdog limit
  localparam int unsigned LEN_W_DEF       = 10;
  localparam int unsigned GAP_CYC_DEF     = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 4096;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter for the frame scheduler.
// Bit 0 is the V requester, bit 1 is the N requester. Purely combinational;
// the caller owns the last-grant register.
module rr_arb2
  import rx_sched_pkg::*;
(
  input  logic [1:0]  req_i,
  input  logic        en_i,
  input  sched_mode_t lastGrant_i,
  output logic [1:0]  gnt_o
);

  // A lone request wins outright; a tie goes to the side that did not win last
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (lastGrant_i == MODE_N) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/rx_frame_sched.sv
// RX-RAM decode frame scheduler for the V (6-bit) and N (4-bit) symbol decoders.
// Grants one of two frame requesters round-robin, latches the frame length into
// weight_pack, opens the data_std window and closes it on flag_down_last_data,
// then holds an idle gap before the next grant. Every output is a register.
// Optional RUN-state watchdog: define RX_SCHED_TIMEOUT_EN to enable it; the
// TIMEOUT_CYC parameter exists only in that build.
module rx_frame_sched
  import rx_sched_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF
`ifdef RX_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic             clk_15_o,
  input  logic             nrst,
  input  logic             req_v,
  input  logic [LEN_W-1:0] len_v,
  input  logic             req_n,
  input  logic [LEN_W-1:0] len_n,
  input  logic             flag_down_last_data,
  output logic             gnt_v,
  output logic             gnt_n,
  output logic             done_v,
  output logic             done_n,
  output logic             data_std,
  output logic             cod_ce_v,
  output logic             cod_ce_n,
  output logic [LEN_W-1:0] weight_pack,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  sched_state_t     state_q;
  sched_mode_t      lastGrant_q;
  logic [GW-1:0]    gapCnt_q;
  logic [LEN_W-1:0] weight_q;
  logic             gntV_q;
  logic             gntN_q;
  logic             doneV_q;
  logic             doneN_q;
  logic             dataStd_q;
  logic             codCeV_q;
  logic             codCeN_q;
  logic             busy_q;

  logic [1:0]       arbGnt;
  logic             runEnd;

  rr_arb2 u_arb (
    .req_i       ({req_n, req_v}),
    .en_i        (state_q == IDLE),
    .lastGrant_i (lastGrant_q),
    .gnt_o       (arbGnt)
  );

`ifdef RX_SCHED_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] runCnt_q;
  logic          timeoutErr_q;
  logic          runExpire;

  assign runExpire   = (runCnt_q == TW'(TIMEOUT_CYC - 1));
  assign runEnd      = flag_down_last_data | runExpire;
  assign timeout_err = timeoutErr_q;
`else
  assign runEnd      = flag_down_last_data;
  assign timeout_err = 1'b0;
`endif

  // Frame sequencing FSM; pulses default low and are raised for one cycle only
  always_ff @(posedge clk_15_o or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      lastGrant_q  <= MODE_N;
      gapCnt_q     <= '0;
      weight_q     <= '0;
      gntV_q       <= 1'b0;
      gntN_q       <= 1'b0;
      doneV_q      <= 1'b0;
      doneN_q      <= 1'b0;
      dataStd_q    <= 1'b0;
      codCeV_q     <= 1'b0;
      codCeN_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef RX_SCHED_TIMEOUT_EN
      runCnt_q     <= '0;
      timeoutErr_q <= 1'b0;
`endif
    end else begin
      gntV_q  <= 1'b0;
      gntN_q  <= 1'b0;
      doneV_q <= 1'b0;
      doneN_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arbGnt[0]) begin
            gntV_q      <= 1'b1;
            weight_q    <= len_v;
            lastGrant_q <= MODE_V;
            codCeV_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
`ifdef RX_SCHED_TIMEOUT_EN
            timeoutErr_q <= 1'b0;
`endif
          end else if (arbGnt[1]) begin
            gntN_q      <= 1'b1;
            weight_q    <= len_n;
            lastGrant_q <= MODE_N;
            codCeN_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
`ifdef RX_SCHED_TIMEOUT_EN
            timeoutErr_q <= 1'b0;
`endif
          end
        end
        LOAD: begin
          dataStd_q <= 1'b1;
          state_q   <= RUN;
`ifdef RX_SCHED_TIMEOUT_EN
          runCnt_q  <= '0;
`endif
        end
        RUN: begin
          if (runEnd) begin
            dataStd_q <= 1'b0;
            doneV_q   <= (lastGrant_q == MODE_V);
            doneN_q   <= (lastGrant_q == MODE_N);
            state_q   <= DRAIN;
`ifdef RX_SCHED_TIMEOUT_EN
            if (!flag_down_last_data) begin
              timeoutErr_q <= 1'b1;
            end
`endif
          end
`ifdef RX_SCHED_TIMEOUT_EN
          else begin
            runCnt_q <= runCnt_q + TW'(1);
          end
`endif
        end
        DRAIN: begin
          codCeV_q <= 1'b0;
          codCeN_q <= 1'b0;
          gapCnt_q <= '0;
          state_q  <= GAP;
        end
        GAP: begin
          if (gapCnt_q == GW'(GAP_CYC - 1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gapCnt_q <= gapCnt_q + GW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_v       = gntV_q;
  assign gnt_n       = gntN_q;
  assign done_v      = doneV_q;
  assign done_n      = doneN_q;
  assign data_std    = dataStd_q;
  assign cod_ce_v    = codCeV_q;
  assign cod_ce_n    = codCeN_q;
  assign weight_pack = weight_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rx_frame_sched.sv
// Directed testbench for rx_frame_sched with hand-computed expectations.
// Build with RX_SCHED_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT_CYC=16).
module tb_rx_frame_sched;

  localparam int unsigned LEN_W = 10;
  localparam int unsigned GAP   = 4;

  logic             clk_15_o;
  logic             nrst;
  logic             req_v;
  logic [LEN_W-1:0] len_v;
  logic             req_n;
  logic [LEN_W-1:0] len_n;
  logic             flag_down_last_data;
  logic             gnt_v;
  logic             gnt_n;
  logic             done_v;
  logic             done_n;
  logic             data_std;
  logic             cod_ce_v;
  logic             cod_ce_n;
  logic [LEN_W-1:0] weight_pack;
  logic             busy;
  logic             timeout_err;

  int checkCount;
  int errorCount;

  rx_frame_sched #(
    .LEN_W   (LEN_W),
    .GAP_CYC (GAP)
`ifdef RX_SCHED_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (16)
`endif
  ) dut (
    .clk_15_o            (clk_15_o),
    .nrst                (nrst),
    .req_v               (req_v),
    .len_v               (len_v),
    .req_n               (req_n),
    .len_n               (len_n),
    .flag_down_last_data (flag_down_last_data),
    .gnt_v               (gnt_v),
    .gnt_n               (gnt_n),
    .done_v              (done_v),
    .done_n              (done_n),
    .data_std            (data_std),
    .cod_ce_v            (cod_ce_v),
    .cod_ce_n            (cod_ce_n),
    .weight_pack         (weight_pack),
    .busy                (busy),
    .timeout_err         (timeout_err)
  );

  // 10 ns decoder clock
  initial clk_15_o = 1'b0;
  always #5 clk_15_o = ~clk_15_o;

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    if (obs !== expv) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Drive the requester and decoder-flag inputs
  task automatic applyStimulus(input logic rv, input logic [LEN_W-1:0] lv,
                               input logic rn, input logic [LEN_W-1:0] ln,
                               input logic fl);
    req_v               = rv;
    len_v               = lv;
    req_n               = rn;
    len_n               = ln;
    flag_down_last_data = fl;
  endtask

  // Advance to 1 ns past the next rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_15_o);
      #1;
    end
  endtask

  // Synchronous-looking reset pulse of two cycles
  task automatic doReset();
    nrst = 1'b0;
    tick(2);
    nrst = 1'b1;
    tick(1);
  endtask

  // Sequenced directed tests
  initial begin
    int frames;
    int gapRun;
    int lastGnt;
    int doneCnt;

    checkCount = 0;
    errorCount = 0;
    nrst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    tick(2);

    // Reset state
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_data_std", data_std, 0);
    checkOutput("rst_cod_ce_v", cod_ce_v, 0);
    checkOutput("rst_cod_ce_n", cod_ce_n, 0);
    checkOutput("rst_weight", weight_pack, 0);
    checkOutput("rst_gnt", {gnt_v, gnt_n, done_v, done_n}, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    nrst = 1'b1;
    tick(1);

    // 1. Single V frame, len 3
    applyStimulus(1'b1, 10'd3, 1'b0, '0, 1'b0);
    tick(1);
    checkOutput("t1_gnt_v", gnt_v, 1);
    checkOutput("t1_gnt_n", gnt_n, 0);
    checkOutput("t1_weight", weight_pack, 3);
    checkOutput("t1_cod_ce_v_load", cod_ce_v, 1);
    checkOutput("t1_data_std_load", data_std, 0);
    checkOutput("t1_busy_load", busy, 1);
    applyStimulus(1'b0, 10'd0, 1'b0, '0, 1'b0);
    tick(1);
    checkOutput("t1_data_std_run", data_std, 1);
    checkOutput("t1_gnt_v_run", gnt_v, 0);
    tick(1);
    checkOutput("t1_data_std_run2", data_std, 1);
    flag_down_last_data = 1'b1;
    tick(1);
    flag_down_last_data = 1'b0;
    checkOutput("t1_data_std_drain", data_std, 0);
    checkOutput("t1_done_v", done_v, 1);
    checkOutput("t1_done_n", done_n, 0);
    checkOutput("t1_cod_ce_v_drain", cod_ce_v, 1);
    tick(1);
    checkOutput("t1_done_v_gap", done_v, 0);
    checkOutput("t1_cod_ce_v_gap", cod_ce_v, 0);
    checkOutput("t1_weight_gap", weight_pack, 3);
    tick(3);
    checkOutput("t1_busy_gap4", busy, 1);
    tick(1);
    checkOutput("t1_busy_idle", busy, 0);

    // 2. Simultaneous requests after reset: V first, N after V's gap
    doReset();
    applyStimulus(1'b1, 10'd5, 1'b1, 10'd7, 1'b0);
    tick(1);
    checkOutput("t2_gnt_v", gnt_v, 1);
    checkOutput("t2_gnt_n_first", gnt_n, 0);
    checkOutput("t2_weight_v", weight_pack, 5);
    req_v = 1'b0;
    tick(1);
    checkOutput("t2_cod_ce_n_vframe", cod_ce_n, 0);
    flag_down_last_data = 1'b1;
    tick(1);
    flag_down_last_data = 1'b0;
    checkOutput("t2_done_v", done_v, 1);
    tick(5);
    checkOutput("t2_gnt_n_idle", gnt_n, 0);
    checkOutput("t2_busy_idle", busy, 0);
    tick(1);
    checkOutput("t2_gnt_n", gnt_n, 1);
    checkOutput("t2_weight_n", weight_pack, 7);
    checkOutput("t2_cod_ce_n", cod_ce_n, 1);
    checkOutput("t2_cod_ce_v", cod_ce_v, 0);
    req_n = 1'b0;
    tick(1);
    checkOutput("t2_data_std_n", data_std, 1);
    flag_down_last_data = 1'b1;
    tick(1);
    flag_down_last_data = 1'b0;
    checkOutput("t2_done_n", done_n, 1);
    checkOutput("t2_done_v_nframe", done_v, 0);
    tick(5);
    checkOutput("t2_busy_end", busy, 0);

    // 3. req_n held across three frames: grants 8 cycles apart, 4 gap cycles each
    applyStimulus(1'b0, '0, 1'b1, 10'd12, 1'b0);
    frames  = 0;
    gapRun  = 0;
    lastGnt = 0;
    doneCnt = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick(1);
      if (done_n) doneCnt++;
      if (gnt_n) begin
        frames++;
        if (frames > 1) begin
          checkOutput("t3_gap_cycles", gapRun, GAP);
          checkOutput("t3_gnt_period", cyc - lastGnt, GAP + 4);
        end
        gapRun  = 0;
        lastGnt = cyc;
        if (frames == 3) req_n = 1'b0;
      end
      if (busy && !cod_ce_n && !cod_ce_v && !data_std && !done_n) gapRun++;
      flag_down_last_data = data_std;
    end
    flag_down_last_data = 1'b0;
    checkOutput("t3_frames", frames, 3);
    checkOutput("t3_dones", doneCnt, 3);
    checkOutput("t3_busy_end", busy, 0);

    // 4. len 0 with flag in the first RUN cycle, and a request dropped before grant
    applyStimulus(1'b1, 10'd0, 1'b0, '0, 1'b0);
    tick(1);
    checkOutput("t4_gnt_v", gnt_v, 1);
    checkOutput("t4_weight0", weight_pack, 0);
    req_v = 1'b0;
    tick(1);
    checkOutput("t4_data_std_run", data_std, 1);
    flag_down_last_data = 1'b1;
    tick(1);
    flag_down_last_data = 1'b0;
    checkOutput("t4_done_v", done_v, 1);
    checkOutput("t4_data_std_drain", data_std, 0);
    tick(1);
    req_n = 1'b1;
    len_n = 10'd8;
    tick(1);
    req_n = 1'b0;
    tick(4);
    checkOutput("t4_busy_idle", busy, 0);
    checkOutput("t4_no_lost_gnt", {gnt_v, gnt_n}, 0);
    tick(1);
    checkOutput("t4_still_idle", busy, 0);

    // 5. Reset pulse during RUN with an N request pending
    applyStimulus(1'b1, 10'd9, 1'b0, '0, 1'b0);
    tick(1);
    checkOutput("t5_weight9", weight_pack, 9);
    req_v = 1'b0;
    tick(1);
    req_n = 1'b1;
    len_n = 10'd2;
    tick(1);
    checkOutput("t5_run", data_std, 1);
    nrst = 1'b0;
    #1;
    checkOutput("t5_rst_data_std", data_std, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_cod_ce_v", cod_ce_v, 0);
    checkOutput("t5_rst_weight", weight_pack, 0);
    tick(1);
    checkOutput("t5_rst_no_done", done_v, 0);
    nrst = 1'b1;
    tick(1);
    checkOutput("t5_gnt_n", gnt_n, 1);
    checkOutput("t5_weight2", weight_pack, 2);
    req_n = 1'b0;
    tick(1);
    flag_down_last_data = 1'b1;
    tick(1);
    flag_down_last_data = 1'b0;
    checkOutput("t5_done_n", done_n, 1);
    checkOutput("t5_timeout_err", timeout_err, 0);
    tick(5);
    checkOutput("t5_busy_end", busy, 0);

`ifdef RX_SCHED_TIMEOUT_EN
    // 6. Watchdog: no flag, forced DRAIN after 16 RUN cycles
    applyStimulus(1'b1, 10'd4, 1'b0, '0, 1'b0);
    tick(1);
    checkOutput("t6_gnt_v", gnt_v, 1);
    req_v = 1'b0;
    tick(16);
    checkOutput("t6_run16", data_std, 1);
    checkOutput("t6_err_before", timeout_err, 0);
    tick(1);
    checkOutput("t6_data_std_drain", data_std, 0);
    checkOutput("t6_done_v", done_v, 1);
    checkOutput("t6_err_set", timeout_err, 1);
    tick(5);
    checkOutput("t6_err_sticky", timeout_err, 1);
    applyStimulus(1'b0, '0, 1'b1, 10'd1, 1'b0);
    tick(1);
    checkOutput("t6_gnt_n", gnt_n, 1);
    checkOutput("t6_err_clear", timeout_err, 0);
    req_n = 1'b0;
    tick(1);
    flag_down_last_data = 1'b1;
    tick(1);
    flag_down_last_data = 1'b0;
    checkOutput("t6_done_n", done_n, 1);
    checkOutput("t6_err_flag_end", timeout_err, 0);
    tick(5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
